// File: rtl/sdhci_card_detect.sv
// Card-detect / write-protect front end: pin synchronisers, CD debounce FSM and
// insertion/removal event pulses for the SDHCI Present State and interrupt logic.
module sdhci_card_detect #(
    parameter int unsigned DebounceCycles = 50000,
    parameter bit          CdActiveLow    = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic card_detect_i,
    input  logic write_protect_i,
    input  logic cd_test_level_i,
    input  logic cd_signal_select_i,
    output logic card_inserted_o,
    output logic card_state_stable_o,
    output logic card_detect_pin_level_o,
    output logic write_protect_pin_level_o,
    output logic card_insertion_o,
    output logic card_removal_o
);

    localparam int unsigned     CntW   = $clog2(DebounceCycles);
    localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

    typedef enum logic [2:0] {
        StInit,
        StRemoved,
        StInserted,
        StDebIns,
        StDebRem
    } state_e;

    logic [1:0]      cd_sync_q;
    logic [1:0]      wp_sync_q;
    logic            pres_pin;
    logic            pres;
    logic            pres_prev_q;
    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            insertion_q;
    logic            removal_q;

    // CD synchroniser resets to the not-present pin level so no phantom card appears.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cd_sync_q <= {2{CdActiveLow}};
            wp_sync_q <= 2'b00;
        end else begin
            cd_sync_q <= {cd_sync_q[0], card_detect_i};
            wp_sync_q <= {wp_sync_q[0], write_protect_i};
        end
    end

    assign pres_pin = cd_sync_q[1] ^ CdActiveLow;
    assign pres     = cd_signal_select_i ? cd_test_level_i : pres_pin;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StInit;
            cnt_q       <= '0;
            pres_prev_q <= 1'b0;
            insertion_q <= 1'b0;
            removal_q   <= 1'b0;
        end else begin
            pres_prev_q <= pres;
            insertion_q <= 1'b0;
            removal_q   <= 1'b0;
            case (state_q)
                StInit: begin
                    if (pres != pres_prev_q) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CntMax) begin
                        state_q <= pres ? StInserted : StRemoved;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StRemoved: begin
                    if (pres) begin
                        state_q <= StDebIns;
                        cnt_q   <= '0;
                    end
                end
                StInserted: begin
                    if (!pres) begin
                        state_q <= StDebRem;
                        cnt_q   <= '0;
                    end
                end
                // A bounce outranks the commit check, even on the last count.
                StDebIns: begin
                    if (!pres) begin
                        state_q <= StRemoved;
                    end else if (cnt_q == CntMax) begin
                        state_q     <= StInserted;
                        insertion_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StDebRem: begin
                    if (pres) begin
                        state_q <= StInserted;
                    end else if (cnt_q == CntMax) begin
                        state_q   <= StRemoved;
                        removal_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: begin
                    state_q <= StInit;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign card_inserted_o           = (state_q == StInserted) || (state_q == StDebRem);
    assign card_state_stable_o       = (state_q == StInserted) || (state_q == StRemoved);
    assign card_detect_pin_level_o   = pres_pin;
    assign write_protect_pin_level_o = wp_sync_q[1];
    assign card_insertion_o          = insertion_q;
    assign card_removal_o            = removal_q;

endmodule

// File: doc/sdhci_card_detect.md
# sdhci_card_detect

Card-detect and write-protect front end for the SDHCI host. It synchronises the raw CD and WP pins and debounces card detect with a state machine. It drives the Present State fields card_inserted, card_state_stable, card_detect_pin_level and write_protect_switch_pin_level. It also produces one-cycle card-insertion and card-removal event pulses for the normal interrupt status logic.

## Interface
- DebounceCycles, default 50000: consecutive equal-level cycles required to commit a CD change (1 ms at 50 MHz); legal range ≥ 2.
- CdActiveLow, default 1: 1 means a low CD pin indicates a card is present.
- clk_i  in  1  system clock; the only clock.
- rst_ni  in  1  asynchronous, active-low reset.
- card_detect_i  in  1  raw CD pin; asynchronous to clk_i.
- write_protect_i  in  1  raw WP pin; asynchronous; 1 means writes are allowed.
- cd_test_level_i  in  1  Host Control card-detect test level; 1 means inserted.
- cd_signal_select_i  in  1  Host Control card-detect signal selection; 1 selects cd_test_level_i instead of the pin.
- card_inserted_o  out  1  debounced insertion state.
- card_state_stable_o  out  1  1 when the FSM is in a committed state.
- card_detect_pin_level_o  out  1  synchronised, inverted-if-active-low CD level (1 means present), not debounced.
- write_protect_pin_level_o  out  1  synchronised WP level.
- card_insertion_o  out  1  one-cycle pulse on a committed insertion.
- card_removal_o  out  1  one-cycle pulse on a committed removal.

## Operation
- Synchronisers:
  - Two-flop synchroniser on card_detect_i.
  - Two-flop synchroniser on write_protect_i; its reset value is 0.
  - The CD synchroniser's reset value is the not-present pin level (1 when CdActiveLow=1).
- Presence signals:
  - pres_pin = sync CD XOR CdActiveLow.
  - pres = cd_signal_select_i ? cd_test_level_i : pres_pin (combinational mux, no extra sync).
- FSM states: INIT, REMOVED, INSERTED, DEB_INS, DEB_REM. A counter cnt of width $clog2(DebounceCycles) is shared across states.
- INIT (the reset state):
  - Each cycle, if pres equals the previous cycle's pres, cnt increments; otherwise cnt is cleared.
  - When cnt reaches DebounceCycles-1, the FSM goes to INSERTED if pres=1, else REMOVED.
  - No event pulse is generated on leaving INIT.
- REMOVED: pres=1 → DEB_INS with cnt←0.
- INSERTED: pres=0 → DEB_REM with cnt←0.
- DEB_INS:
  - pres=0 → REMOVED, no pulse.
  - pres=1 and cnt=DebounceCycles-1 → INSERTED, and card_insertion_o pulses.
  - Otherwise cnt++.
- DEB_REM: mirror of DEB_INS.
  - pres=1 → INSERTED, no pulse.
  - Commit → REMOVED, and card_removal_o pulses.
- Output decode:
  - card_inserted_o = 1 in INSERTED and DEB_REM.
  - card_state_stable_o = 1 in REMOVED and INSERTED only.
- Switching cd_signal_select_i is an ordinary level change and is debounced.
- All outputs are registered or decoded directly from state registers; no output is a combinational path from an input.

## Timing
- Reset values: all outputs 0; FSM in INIT; cnt 0.
- card_detect_pin_level_o reset value is 0 (not present).
- Pin-to-level latency: 2 cycles after a pin edge, card_detect_pin_level_o and write_protect_pin_level_o update.
- Debounce latency: pres changes in cycle t → DEB state in t+1 → commit in t+DebounceCycles.
- At commit, card_inserted_o changes and the pulse is high in that same cycle for exactly one cycle.
- Debounce latency (pin): pin edge to commit is 2+DebounceCycles cycles.
- Glitch: any single opposite-level cycle during DEB aborts the debounce, and the full count restarts on the next change.
- A bounce in the same cycle as the commit check (pres mismatch while cnt=DebounceCycles-1) aborts; mismatch has priority over commit.
- card_insertion_o and card_removal_o are never high in the same cycle. Two pulses of opposite kind are separated by at least DebounceCycles+1 cycles.
- Asynchronous reset mid-debounce:
  - Outputs drop to 0 immediately and the FSM returns to INIT.
  - No pulse is generated on reset or reset release.

## Test plan
- Reset release with pin held present (card_detect_i=0), DebounceCycles=8:
  - card_state_stable_o=1 and card_inserted_o=1 at cycle 2+8 after release.
  - No insertion pulse.
- From REMOVED, pin held present:
  - card_insertion_o is high for exactly 1 cycle, 10 cycles after the pin edge.
  - card_state_stable_o is low for the 8 DEB cycles in between.
- From INSERTED, 3-cycle removal glitch:
  - DEB_REM is entered then aborted.
  - card_inserted_o stays 1 and card_removal_o stays 0 throughout.
- Test mode: cd_signal_select_i=1, cd_test_level_i=1 while the pin reads absent:
  - Insertion pulse after 8 cycles.
  - card_detect_pin_level_o stays 0.
  - Dropping cd_signal_select_i gives a removal pulse 8 cycles later.
- rst_ni asserted at cnt=5 in DEB_INS:
  - All outputs are 0 at once.
  - After release with the pin present, the FSM commits via INIT with no pulse.
- Toggle write_protect_i: write_protect_pin_level_o follows with 2-cycle latency; CD state is unaffected.
